// File: rtl/axil_rw_arbiter.sv
// AXI4-Lite front end for the GPIO register bank.
// Buffers AW/W/AR, grants one register access at a time round-robin.
module axil_rw_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                iCLK,
  input  logic                iRSTN,
  input  logic [ADDR_W-1:0]   iAWADDR,
  input  logic                iAWVALID,
  output logic                oAWREADY,
  input  logic [DATA_W-1:0]   iWDATA,
  input  logic [DATA_W/8-1:0] iWSTRB,
  input  logic                iWVALID,
  output logic                oWREADY,
  output logic [1:0]          oBRESP,
  output logic                oBVALID,
  input  logic                iBREADY,
  input  logic [ADDR_W-1:0]   iARADDR,
  input  logic                iARVALID,
  output logic                oARREADY,
  output logic [DATA_W-1:0]   oRDATA,
  output logic [1:0]          oRRESP,
  output logic                oRVALID,
  input  logic                iRREADY,
  output logic [ADDR_W-1:0]   oREG_ADDR,
  output logic                oREG_WR,
  output logic                oREG_RD,
  output logic [DATA_W-1:0]   oREG_WDATA,
  output logic [DATA_W/8-1:0] oREG_WSTRB,
  input  logic [DATA_W-1:0]   iREG_RDATA,
  input  logic                iREG_ERR
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t state;
  state_t stateNext;

  logic              awFull;
  logic              wFull;
  logic              arFull;
  logic [ADDR_W-1:0] awAddr;
  logic [DATA_W-1:0] wData;
  logic [STRB_W-1:0] wStrb;
  logic [ADDR_W-1:0] arAddr;
  logic              lastGrantWr;
  logic              wrErr;
  logic [DATA_W-1:0] rData;
  logic              rErr;

  logic wrPend;
  logic rdPend;
  logic grantWr;
  logic grantRd;
  logic bDone;
  logic rDone;

  assign wrPend = awFull & wFull;
  assign rdPend = arFull;
  assign bDone  = (state == WR_RESP) & iBREADY;
  assign rDone  = (state == RD_RESP) & iRREADY;

  always_comb begin
    stateNext = state;
    grantWr   = 1'b0;
    grantRd   = 1'b0;
    unique case (state)
      IDLE: begin
        // on a tie the type that did not win last time goes first
        grantWr = wrPend & (~rdPend | ~lastGrantWr);
        grantRd = rdPend & (~wrPend | lastGrantWr);
        if (grantWr) begin
          stateNext = WR;
        end else if (grantRd) begin
          stateNext = RD;
        end
      end
      WR:      stateNext = WR_RESP;
      WR_RESP: if (iBREADY) stateNext = IDLE;
      RD:      stateNext = RD_WAIT;
      RD_WAIT: stateNext = RD_RESP;
      RD_RESP: if (iRREADY) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      awFull <= 1'b0;
      awAddr <= '0;
    end else if (bDone) begin
      awFull <= 1'b0;
    end else if (iAWVALID && !awFull) begin
      awFull <= 1'b1;
      awAddr <= iAWADDR;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      wFull <= 1'b0;
      wData <= '0;
      wStrb <= '0;
    end else if (bDone) begin
      wFull <= 1'b0;
    end else if (iWVALID && !wFull) begin
      wFull <= 1'b1;
      wData <= iWDATA;
      wStrb <= iWSTRB;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      arFull <= 1'b0;
      arAddr <= '0;
    end else if (rDone) begin
      arFull <= 1'b0;
    end else if (iARVALID && !arFull) begin
      arFull <= 1'b1;
      arAddr <= iARADDR;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      lastGrantWr <= 1'b1;
    end else if (grantWr) begin
      lastGrantWr <= 1'b1;
    end else if (grantRd) begin
      lastGrantWr <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      wrErr <= 1'b0;
    end else if (state == WR) begin
      wrErr <= iREG_ERR;
    end
  end

  // read data arrives one cycle after the strobe
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      rData <= '0;
      rErr  <= 1'b0;
    end else if (state == RD_WAIT) begin
      rData <= iREG_RDATA;
      rErr  <= iREG_ERR;
    end
  end

  assign oAWREADY = ~awFull;
  assign oWREADY  = ~wFull;
  assign oARREADY = ~arFull;

  assign oBVALID = (state == WR_RESP);
  assign oBRESP  = {wrErr, 1'b0};
  assign oRVALID = (state == RD_RESP);
  assign oRRESP  = {rErr, 1'b0};
  assign oRDATA  = rData;

  assign oREG_WR    = (state == WR);
  assign oREG_RD    = (state == RD);
  assign oREG_ADDR  = oREG_WR ? awAddr :
                      oREG_RD ? arAddr : '0;
  assign oREG_WDATA = oREG_WR ? wData : '0;
  assign oREG_WSTRB = oREG_WR ? wStrb : '0;

endmodule

// File: tb/tb_axil_rw_arbiter.sv
// Bench for axil_rw_arbiter: vector table, corner sequences,
// random traffic against a register-bank reference model.
module tb_axil_rw_arbiter;

  logic        iCLK = 1'b0;
  logic        iRSTN = 1'b1;
  logic [31:0] iAWADDR = '0;
  logic        iAWVALID = 1'b0;
  logic        oAWREADY;
  logic [31:0] iWDATA = '0;
  logic [3:0]  iWSTRB = '0;
  logic        iWVALID = 1'b0;
  logic        oWREADY;
  logic [1:0]  oBRESP;
  logic        oBVALID;
  logic        iBREADY = 1'b0;
  logic [31:0] iARADDR = '0;
  logic        iARVALID = 1'b0;
  logic        oARREADY;
  logic [31:0] oRDATA;
  logic [1:0]  oRRESP;
  logic        oRVALID;
  logic        iRREADY = 1'b0;
  logic [31:0] oREG_ADDR;
  logic        oREG_WR;
  logic        oREG_RD;
  logic [31:0] oREG_WDATA;
  logic [3:0]  oREG_WSTRB;
  logic [31:0] iREG_RDATA = '0;
  logic        iREG_ERR = 1'b0;

  axil_rw_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN),
    .iAWADDR(iAWADDR), .iAWVALID(iAWVALID), .oAWREADY(oAWREADY),
    .iWDATA(iWDATA), .iWSTRB(iWSTRB), .iWVALID(iWVALID),
    .oWREADY(oWREADY),
    .oBRESP(oBRESP), .oBVALID(oBVALID), .iBREADY(iBREADY),
    .iARADDR(iARADDR), .iARVALID(iARVALID), .oARREADY(oARREADY),
    .oRDATA(oRDATA), .oRRESP(oRRESP), .oRVALID(oRVALID),
    .iRREADY(iRREADY),
    .oREG_ADDR(oREG_ADDR), .oREG_WR(oREG_WR), .oREG_RD(oREG_RD),
    .oREG_WDATA(oREG_WDATA), .oREG_WSTRB(oREG_WSTRB),
    .iREG_RDATA(iREG_RDATA), .iREG_ERR(iREG_ERR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // register bank model: addr[5:2] selects a word, addr[8] flags an error
  logic [31:0] mem [16];
  bit          prevWr;
  bit          prevRd;
  logic [31:0] rdHold;
  bit          rdErrHold;
  bit          wrSeen;
  bit          rdSeen;
  int          wrCount = 0;
  bit          accLog[$];

  function automatic bit errOf(input logic [31:0] a);
    return a[8];
  endfunction

  task automatic tick();
    bit e;
    @(negedge iCLK);
    wrSeen = 0;
    rdSeen = 0;
    if (!iRSTN) begin
      prevWr = 0;
      prevRd = 0;
      return;
    end
    if (oREG_WR || oREG_RD) begin
      chk("wr_rd_exclusive", oREG_WR & oREG_RD, 0);
      chk("no_back_to_back", prevWr | prevRd, 0);
      chk("no_access_in_resp", oBVALID | oRVALID, 0);
    end
    if (oREG_WR) begin
      wrSeen = 1;
      wrCount++;
      accLog.push_back(1'b1);
      e = errOf(oREG_ADDR);
      iREG_ERR = e;
      if (!e) begin
        for (int b = 0; b < 4; b++)
          if (oREG_WSTRB[b])
            mem[oREG_ADDR[5:2]][8*b +: 8] = oREG_WDATA[8*b +: 8];
      end
    end else if (prevRd) begin
      iREG_RDATA = rdHold;
      iREG_ERR = rdErrHold;
    end else begin
      iREG_RDATA = $urandom;
      iREG_ERR = 1'($urandom_range(0, 1));
    end
    if (oREG_RD) begin
      rdSeen = 1;
      accLog.push_back(1'b0);
      rdHold = mem[oREG_ADDR[5:2]];
      rdErrHold = errOf(oREG_ADDR);
    end
    prevWr = oREG_WR;
    prevRd = oREG_RD;
  endtask

  task automatic applyReset();
    iRSTN = 0;
    iAWVALID = 0;
    iWVALID = 0;
    iARVALID = 0;
    iBREADY = 0;
    iRREADY = 0;
    #1;
    chk("rst_awready", oAWREADY, 1);
    chk("rst_wready", oWREADY, 1);
    chk("rst_arready", oARREADY, 1);
    chk("rst_bvalid", oBVALID, 0);
    chk("rst_rvalid", oRVALID, 0);
    chk("rst_reg_wr", oREG_WR, 0);
    chk("rst_reg_rd", oREG_RD, 0);
    chk("rst_resps", {oBRESP, oRRESP}, 0);
    chk("rst_rdata", oRDATA, 0);
    chk("rst_reg_bus", {oREG_ADDR, oREG_WDATA}, 0);
    chk("rst_reg_wstrb", oREG_WSTRB, 0);
    tick();
    tick();
    iRSTN = 1;
  endtask

  task automatic runWrite(logic [31:0] a, logic [31:0] d,
                          logic [3:0] s, logic [1:0] resp);
    iAWADDR = a;
    iWDATA = d;
    iWSTRB = s;
    iAWVALID = 1;
    iWVALID = 1;
    iBREADY = 1;
    tick();
    chk("wr_awready_low", oAWREADY, 0);
    chk("wr_wready_low", oWREADY, 0);
    chk("wr_early", oREG_WR, 0);
    iAWVALID = 0;
    iWVALID = 0;
    tick();
    chk("wr_strobe", oREG_WR, 1);
    chk("wr_addr", oREG_ADDR, a);
    chk("wr_data", oREG_WDATA, d);
    chk("wr_strb", oREG_WSTRB, s);
    tick();
    chk("wr_strobe_1cyc", oREG_WR, 0);
    chk("wr_bvalid", oBVALID, 1);
    chk("wr_bresp", oBRESP, resp);
    tick();
    chk("wr_bvalid_drop", oBVALID, 0);
    chk("wr_ready_again", {oAWREADY, oWREADY}, 2'b11);
  endtask

  task automatic runRead(logic [31:0] a, logic [31:0] d,
                         logic [1:0] resp, int stall);
    iARADDR = a;
    iARVALID = 1;
    iRREADY = (stall == 0);
    tick();
    chk("rd_arready_low", oARREADY, 0);
    iARVALID = 0;
    tick();
    chk("rd_strobe", oREG_RD, 1);
    chk("rd_addr", oREG_ADDR, a);
    tick();
    chk("rd_wait_rvalid", oRVALID, 0);
    tick();
    chk("rd_rvalid", oRVALID, 1);
    chk("rd_rdata", oRDATA, d);
    chk("rd_rresp", oRRESP, resp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("rd_hold_valid", oRVALID, 1);
      chk("rd_hold_data", {oRRESP, oRDATA}, {resp, d});
    end
    iRREADY = 1;
    tick();
    chk("rd_rvalid_drop", oRVALID, 0);
    chk("rd_arready_again", oARREADY, 1);
  endtask

  typedef struct {
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expData;
    logic [1:0]  expResp;
  } vec_t;

  vec_t vecs[7];

  // random-phase scoreboard
  logic [31:0] awQ[$];
  logic [35:0] wQ[$];
  logic [31:0] arQ[$];
  logic [1:0]  bQ[$];
  logic [33:0] rQ[$];
  bit awHs;
  bit wHs;
  bit arHs;

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 7) == 0) a[8] = 1'b1;
    return a;
  endfunction

  task automatic randStep(bit allowNew);
    bit ok;
    tick();
    if (wrSeen) begin
      ok = (awQ.size() != 0) && (wQ.size() != 0);
      chk("rnd_wr_pending", ok, 1);
      if (ok) begin
        chk("rnd_wr_addr", oREG_ADDR, awQ.pop_front());
        chk("rnd_wr_data", {oREG_WSTRB, oREG_WDATA}, wQ.pop_front());
        bQ.push_back(errOf(oREG_ADDR) ? 2'b10 : 2'b00);
      end
    end
    if (rdSeen) begin
      ok = arQ.size() != 0;
      chk("rnd_rd_pending", ok, 1);
      if (ok) begin
        chk("rnd_rd_addr", oREG_ADDR, arQ.pop_front());
        rQ.push_back({rdErrHold ? 2'b10 : 2'b00, rdHold});
      end
    end
    iBREADY = !allowNew || ($urandom_range(0, 2) != 0);
    iRREADY = !allowNew || ($urandom_range(0, 2) != 0);
    if (oBVALID && iBREADY) begin
      ok = bQ.size() != 0;
      chk("rnd_b_expected", ok, 1);
      if (ok) chk("rnd_bresp", oBRESP, bQ.pop_front());
    end
    if (oRVALID && iRREADY) begin
      ok = rQ.size() != 0;
      chk("rnd_r_expected", ok, 1);
      if (ok) chk("rnd_rdata", {oRRESP, oRDATA}, rQ.pop_front());
    end
    if (awHs) iAWVALID = 0;
    if (wHs) iWVALID = 0;
    if (arHs) iARVALID = 0;
    if (!iAWVALID && allowNew && $urandom_range(0, 3) == 0) begin
      iAWVALID = 1;
      iAWADDR = randAddr();
    end
    if (!iWVALID && allowNew && $urandom_range(0, 3) == 0) begin
      iWVALID = 1;
      iWDATA = $urandom;
      iWSTRB = 4'($urandom_range(0, 15));
    end
    if (!iARVALID && allowNew && $urandom_range(0, 3) == 0) begin
      iARVALID = 1;
      iARADDR = randAddr();
    end
    awHs = iAWVALID && oAWREADY;
    wHs = iWVALID && oWREADY;
    arHs = iARVALID && oARREADY;
    if (awHs) awQ.push_back(iAWADDR);
    if (wHs) wQ.push_back({iWSTRB, iWDATA});
    if (arHs) arQ.push_back(iARADDR);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[2] = 32'h1234_5678;

    vecs[0] = '{1, 32'h04,  32'hA5A5_0F0F, 4'hF, 32'h0, 2'b00};
    vecs[1] = '{0, 32'h04,  32'h0, 4'h0, 32'hA5A5_0F0F, 2'b00};
    vecs[2] = '{1, 32'h04,  32'h1122_3344, 4'h5, 32'h0, 2'b00};
    vecs[3] = '{0, 32'h04,  32'h0, 4'h0, 32'hA522_0F44, 2'b00};
    vecs[4] = '{1, 32'h104, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b10};
    vecs[5] = '{0, 32'h104, 32'h0, 4'h0, 32'hA522_0F44, 2'b10};
    vecs[6] = '{0, 32'h08,  32'h0, 4'h0, 32'h1234_5678, 2'b00};

    #3;
    applyReset();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].isWr)
        runWrite(vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].expResp);
      else
        runRead(vecs[i].addr, vecs[i].expData, vecs[i].expResp, 0);
    end

    // W accepted three cycles ahead of AW
    base = wrCount;
    iWDATA = 32'hCAFE_F00D;
    iWSTRB = 4'hF;
    iWVALID = 1;
    iBREADY = 1;
    tick();
    chk("wfirst_wready_low", oWREADY, 0);
    chk("wfirst_awready", oAWREADY, 1);
    iWVALID = 0;
    tick();
    chk("wfirst_no_wr1", oREG_WR, 0);
    tick();
    chk("wfirst_no_wr2", oREG_WR, 0);
    iAWADDR = 32'h0C;
    iAWVALID = 1;
    tick();
    chk("wfirst_no_wr3", oREG_WR, 0);
    chk("wfirst_wready_held", oWREADY, 0);
    iAWVALID = 0;
    tick();
    chk("wfirst_strobe", oREG_WR, 1);
    chk("wfirst_bus", {oREG_ADDR, oREG_WDATA}, {32'h0C, 32'hCAFE_F00D});
    tick();
    chk("wfirst_bvalid", {oBVALID, oBRESP}, 3'b100);
    tick();
    chk("wfirst_single", wrCount - base, 1);
    chk("wfirst_ready", {oAWREADY, oWREADY}, 2'b11);

    runRead(32'h08, 32'h1234_5678, 2'b00, 4);

    // simultaneous write and read right after reset: read wins
    applyReset();
    accLog.delete();
    iAWADDR = 32'h10;
    iWDATA = 32'h0BAD_F00D;
    iWSTRB = 4'hF;
    iARADDR = 32'h10;
    iAWVALID = 1;
    iWVALID = 1;
    iARVALID = 1;
    iBREADY = 1;
    iRREADY = 1;
    tick();
    iAWVALID = 0;
    iWVALID = 0;
    iARVALID = 0;
    repeat (12) tick();
    chk("rr1_count", accLog.size(), 2);
    if (accLog.size() == 2) chk("rr1_order", {accLog[0], accLog[1]}, 2'b01);
    runRead(32'h10, 32'h0BAD_F00D, 2'b00, 0);

    // last grant was a read, so the next tie goes to the write
    accLog.delete();
    iAWADDR = 32'h14;
    iWDATA = 32'h55AA_55AA;
    iARADDR = 32'h14;
    iAWVALID = 1;
    iWVALID = 1;
    iARVALID = 1;
    tick();
    iAWVALID = 0;
    iWVALID = 0;
    iARVALID = 0;
    repeat (12) tick();
    chk("rr2_count", accLog.size(), 2);
    if (accLog.size() == 2) chk("rr2_order", {accLog[0], accLog[1]}, 2'b10);

    // reset while the read is waiting for register data
    iARADDR = 32'h08;
    iARVALID = 1;
    iRREADY = 1;
    tick();
    iARVALID = 0;
    tick();
    chk("rstmid_rd", oREG_RD, 1);
    tick();
    applyReset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmid_no_rvalid", oRVALID, 0);
    end
    runRead(32'h08, 32'h1234_5678, 2'b00, 0);

    awHs = 0;
    wHs = 0;
    arHs = 0;
    for (int i = 0; i < 3000; i++) randStep(1);
    for (int i = 0; i < 60; i++) randStep(0);
    chk("rnd_drained",
        awQ.size() + wQ.size() + arQ.size() + bQ.size() + rQ.size(), 0);
    chk("rnd_idle_ready", {oAWREADY, oWREADY, oARREADY}, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_rw_arbiter.md
Name: axil_rw_arbiter

Overview:
Shares the single register-bank access port of the AXI4-Lite GPIO slave between the write path (AW+W) and the read path (AR). Each address/data channel is buffered in a one-entry holding register. Pending reads and writes are granted round-robin, one register access at a time. The block generates the B and R responses and backpressures each channel while its holding register is occupied.

Parameters:
ADDR_W, 32, width of AXI and register-port address
DATA_W, 32, width of data buses (WSTRB width = DATA_W/8)

Ports:
iCLK  in  1  clock
iRSTN  in  1  reset
iAWADDR  in  ADDR_W  write address
iAWVALID  in  1  write address valid
oAWREADY  out  1  write address ready
iWDATA  in  DATA_W  write data
iWSTRB  in  DATA_W/8  write byte strobes
iWVALID  in  1  write data valid
oWREADY  out  1  write data ready
oBRESP  out  2  write response (00 OKAY, 10 SLVERR)
oBVALID  out  1  write response valid
iBREADY  in  1  write response ready
iARADDR  in  ADDR_W  read address
iARVALID  in  1  read address valid
oARREADY  out  1  read address ready
oRDATA  out  DATA_W  read data
oRRESP  out  2  read response
oRVALID  out  1  read response valid
iRREADY  in  1  read response ready
oREG_ADDR  out  ADDR_W  register-port address
oREG_WR  out  1  register write strobe, one cycle
oREG_RD  out  1  register read strobe, one cycle
oREG_WDATA  out  DATA_W  register write data
oREG_WSTRB  out  DATA_W/8  register byte enables
iREG_RDATA  in  DATA_W  register read data, valid the cycle after oREG_RD
iREG_ERR  in  1  access error, valid with oREG_WR, or with iREG_RDATA for reads

Behaviour:
- Reset iRSTN: asynchronous, active-low. Clock iCLK.
- Reset values: all holding flags clear; oAWREADY = oWREADY = oARREADY = 1; oBVALID = oRVALID = oREG_WR = oREG_RD = 0; oBRESP = oRRESP = 00; oRDATA, oREG_ADDR, oREG_WDATA, oREG_WSTRB = 0; state IDLE; last_grant = WRITE, so a read wins the first tie.
- Holding registers aw_full, w_full, ar_full:
  - Each is set on its channel's VALID&READY and captures the payload.
  - oXREADY = ~x_full; all READYs are registered and never combinational from VALID.
  - AW and W are accepted independently, in either order.
- A write is pending when aw_full & w_full. A read is pending when ar_full.
- FSM states: IDLE, WR, WR_RESP, RD, RD_WAIT, RD_RESP.
- IDLE:
  - Only write pending -> WR. Only read pending -> RD.
  - Both pending -> the type opposite last_grant; last_grant updates on every grant.
  - Pending flags set at edge N are seen by IDLE in cycle N+1, so the grant takes effect at edge N+1.
- WR (1 cycle): oREG_WR = 1 with held address, data and strobes. Sample iREG_ERR. -> WR_RESP.
- WR_RESP: oBVALID = 1; oBRESP = 10 if the sampled error was set, else 00. On iBREADY: clear aw_full and w_full, drop oBVALID, -> IDLE.
- RD (1 cycle): oREG_RD = 1 with held address. -> RD_WAIT.
- RD_WAIT (1 cycle): capture iREG_RDATA into oRDATA and iREG_ERR into oRRESP (10/00). -> RD_RESP.
- RD_RESP: oRVALID = 1 with oRDATA and oRRESP stable. On iRREADY: clear ar_full, -> IDLE.
- Latency:
  - Write: oBVALID rises 2 cycles after the later of the AW/W handshake edges.
  - Read: oRVALID rises 3 cycles after the AR handshake edge.
- New AW/W/AR may be accepted into empty holding registers while another transaction is in progress. The channel being serviced stays not-ready until its response completes.
- oREG_WR and oREG_RD are never high together, and never high for 2 consecutive cycles.
- While a response is stalled (BREADY or RREADY low), no further register access is granted.
- Reset mid-operation: flags, FSM and all outputs return to reset values immediately; the in-flight access and response are dropped.

Test Plan:
- Write, AW and W same cycle, addr 0x04, data 0xA5A5_0F0F, strb 0xF, iBREADY = 1 -> one-cycle oREG_WR with those values 1 cycle later; oBVALID/oBRESP = 00 the next cycle; AW/W ready again after the B handshake.
- W three cycles before AW -> oWREADY low after the W handshake; no oREG_WR until the AW handshake; single write issued, data intact.
- Read, addr 0x08, iREG_RDATA = 0x1234_5678 the cycle after oREG_RD -> oRVALID rises 3 cycles after the AR handshake with oRDATA = 0x1234_5678 and oRRESP = 00; held through 4 cycles of iRREADY = 0.
- AW+W and AR handshake in the same cycle, after reset -> read granted first, then the write; a second simultaneous pair -> write first (round-robin).
- iREG_ERR = 1 during oREG_WR -> oBRESP = 10; iREG_ERR = 1 in a read data cycle -> oRRESP = 10.
- iRSTN low during RD_WAIT -> oRVALID stays 0; READYs = 1; next read proceeds normally.
